// File: rtl/spi0_bus_arbiter_if.sv
// Bundle of requester, SPI engine and framing signals around the SPI0 arbiter.
// master: the arbiter's view; slave: the requesters/engine side.
interface spi0_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       rsp0_valid;
  logic [7:0] rsp0_data;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       rsp1_valid;
  logic [7:0] rsp1_data;
  logic       eng_cmd_valid;
  logic       eng_cmd_ready;
  logic [7:0] eng_cmd_data;
  logic       eng_rsp_valid;
  logic [7:0] eng_rsp_data;
  logic       spi0_ss;
  logic [1:0] grant;
  logic       abort;

  modport master (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
           eng_cmd_ready, eng_rsp_valid, eng_rsp_data,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           eng_cmd_valid, eng_cmd_data, spi0_ss, grant, abort
  );

  modport slave (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
           eng_cmd_ready, eng_rsp_valid, eng_rsp_data,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
           eng_cmd_valid, eng_cmd_data, spi0_ss, grant, abort
  );
endinterface

// File: rtl/spi0_bus_arbiter.sv
// Round-robin arbiter sharing the SPI0 byte engine between two requesters, with ss framing.
// Optional stall timeout/abort enabled by defining SPI0_ARB_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | ss high, no owner; pick a requester
// SETUP    | ss low, waiting SS_SETUP cycles
// ISSUE    | granted requester passed through to engine
// WAIT_RSP | one byte outstanding, waiting for engine response
// HOLD     | ss low, waiting SS_HOLD cycles before release
module spi0_bus_arbiter #(
  parameter int SS_SETUP       = 2,
  parameter int SS_HOLD        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic io_clock,
  input logic io_reset,
  spi0_bus_arbiter_if.master bus
);
  localparam int MAX_A = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT_RSP, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            ss_q, ss_d;
  logic            ptr_q, ptr_d;
  logic            last_q, last_d;
  logic            abort_c;
  logic            rsp_fwd;
  logic            g_valid, g_last;
  logic [7:0]      g_data;

  assign g_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
  assign g_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
  assign g_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;

`ifdef SPI0_ARB_TIMEOUT_EN
  logic [CW-1:0] tmo_q, tmo_d;
  logic          drop_q, drop_d;
  // a response owed to an aborted byte is swallowed whenever it turns up
  assign rsp_fwd = bus.eng_rsp_valid && !drop_q;
`else
  assign rsp_fwd = bus.eng_rsp_valid;
`endif

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    grant_d           = grant_q;
    ss_d              = ss_q;
    ptr_d             = ptr_q;
    last_d            = last_q;
    abort_c           = 1'b0;
    bus.eng_cmd_valid = 1'b0;
    bus.eng_cmd_data  = 8'h00;
    bus.req0_ready    = 1'b0;
    bus.req1_ready    = 1'b0;
    bus.rsp0_valid    = 1'b0;
    bus.rsp1_valid    = 1'b0;
    bus.rsp0_data     = 8'h00;
    bus.rsp1_data     = 8'h00;
`ifdef SPI0_ARB_TIMEOUT_EN
    tmo_d  = 0;
    drop_d = drop_q && !bus.eng_rsp_valid;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant_d = (bus.req0_valid && (!bus.req1_valid || !ptr_q)) ? 2'b01 : 2'b10;
          ss_d    = 1'b0;
          cnt_d   = CW'(SS_SETUP - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 0) state_d = ISSUE;
        else            cnt_d   = cnt_q - CW'(1);
      end
      ISSUE: begin
        bus.eng_cmd_valid = g_valid;
        bus.eng_cmd_data  = g_data;
        if (grant_q[1]) bus.req1_ready = bus.eng_cmd_ready;
        else            bus.req0_ready = bus.eng_cmd_ready;
        if (g_valid && bus.eng_cmd_ready) begin
          last_d  = g_last;
          state_d = WAIT_RSP;
        end
`ifdef SPI0_ARB_TIMEOUT_EN
        else if (!g_valid) begin
          if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
            abort_c = 1'b1;
            cnt_d   = CW'(SS_HOLD - 1);
            state_d = HOLD;
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end else begin
          tmo_d = tmo_q;
        end
`endif
      end
      WAIT_RSP: begin
        if (rsp_fwd) begin
          if (grant_q[1]) begin
            bus.rsp1_valid = 1'b1;
            bus.rsp1_data  = bus.eng_rsp_data;
          end else begin
            bus.rsp0_valid = 1'b1;
            bus.rsp0_data  = bus.eng_rsp_data;
          end
          if (last_q) begin
            cnt_d   = CW'(SS_HOLD - 1);
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
`ifdef SPI0_ARB_TIMEOUT_EN
        else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
          abort_c = 1'b1;
          drop_d  = 1'b1;
          cnt_d   = CW'(SS_HOLD - 1);
          state_d = HOLD;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
`endif
      end
      HOLD: begin
        if (cnt_q == 0) begin
          ss_d    = 1'b1;
          grant_d = 2'b00;
          ptr_d   = ~ptr_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      ss_q    <= 1'b1;
      ptr_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef SPI0_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ss_q    <= ss_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
`ifdef SPI0_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
`endif
    end
  end

  assign bus.spi0_ss = ss_q;
  assign bus.grant   = grant_q;
  assign bus.abort   = abort_c;
endmodule
